md_wb_scheduler: RTL

- Sequences the multi-cycle multiply/divide unit and schedules its result onto the single register-file write port.
- Sits between execute and writeback.
- Freezes the front of the pipeline while an operation is in flight and lets older instructions drain through writeback.
- Arbitrates the write port: normal writeback has priority; the mult/div result is buffered until the port is free. Exceptions are redirected to $rstatus (r30) with a status code.

---
 rtl/md_wb_scheduler.sv | 84 ++++++++
 1 files changed

// File: rtl/md_wb_scheduler.sv
// md_wb_scheduler: sequences the multi-cycle mult/div unit and merges its result
// onto the single register-file write port behind normal writeback traffic.
module md_wb_scheduler #(
  parameter int unsigned MAX_CYCLES   = 40,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5,
  parameter int unsigned STATUS_REG   = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_start_mul,
  input  logic        md_start_div,
  input  logic [4:0]  md_rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic        unit_result_rdy,
  input  logic        unit_exception,
  input  logic [31:0] unit_result,
  input  logic        wb_in_valid,
  input  logic [4:0]  wb_in_reg,
  input  logic [31:0] wb_in_data,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, WAIT, PEND} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rd;
  logic        r_is_div;
  logic [4:0]  r_pend_reg;
  logic [31:0] r_pend_data;
  logic        r_timeout;
  logic        w_idle;
  logic        w_pend_wr;
  assign w_idle    = !reset && r_state == IDLE;
  assign w_pend_wr = !reset && r_state == PEND && !wb_in_valid;
  assign ctrl_MULT = w_idle && md_start_mul;
  assign ctrl_DIV  = w_idle && md_start_div;
  assign stall     = !reset && (r_state == IDLE ? (md_start_mul || md_start_div) :
                                r_state == WAIT ? 1'b1 : wb_in_valid);
  // The buffered result only takes the port on a cycle with no normal writeback.
  assign wb_we     = w_pend_wr ? r_pend_reg != 5'd0 : wb_in_valid && wb_in_reg != 5'd0;
  assign wb_reg    = w_pend_wr ? r_pend_reg : wb_in_reg;
  assign wb_data   = w_pend_wr ? r_pend_data : wb_in_data;
  assign busy      = r_state != IDLE;
  assign timeout   = r_timeout;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_is_div    <= 1'b0;
      r_pend_reg  <= '0;
      r_pend_data <= '0;
      r_timeout   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (md_start_mul || md_start_div) begin
        r_rd     <= md_rd;
        r_is_div <= md_start_div;
        r_cnt    <= '0;
        r_state  <= WAIT;
      end
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + 8'd1;
      if (unit_result_rdy) begin
        r_pend_reg  <= unit_exception ? 5'(STATUS_REG) : r_rd;
        r_pend_data <= !unit_exception ? unit_result :
                       r_is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
        r_state     <= PEND;
      end else if (r_cnt == 8'(MAX_CYCLES - 1)) begin
        r_timeout   <= 1'b1;
        r_pend_reg  <= 5'(STATUS_REG);
        r_pend_data <= 32'(DIV_EXC_CODE);
        r_state     <= PEND;
      end
    end else if (!wb_in_valid) begin
      r_state <= IDLE;
    end
  end
endmodule
